seq_mag_cmp: RTL and testbench

SEQ_MAG_CMP -- requirements
Module: seq_mag_cmp

---
 rtl/seq_mag_cmp_pkg.sv | 38 +++
 rtl/seq_mag_cmp_cmp_word.sv | 40 ++++
 rtl/seq_mag_cmp.sv | 161 ++++++++++++++++
 tb/tb_seq_mag_cmp.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mag_cmp_pkg.sv
// ----------------------------------------------------------------------------
// seq_mag_cmp_pkg
// Shared definitions for the sequential magnitude comparator:
//   - state_t : FSM state encodings (IDLE, RUN, DONE)
//   - res_t   : sticky compare result codes (EQ, GT, LT)
//   - res_to_flags_n : maps a result code onto the active-low output triple
//                      {p_eq_q_n, p_gt_q_n, p_lt_q_n}
// ----------------------------------------------------------------------------
package seq_mag_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ = 2'b00,
        RES_GT = 2'b01,
        RES_LT = 2'b10
    } res_t;

    // All flags deasserted (active-low): no valid result.
    localparam logic [2:0] FLAGS_NONE = 3'b111;

    // Result code -> {eq_n, gt_n, lt_n}; exactly one bit low for a valid code.
    function automatic logic [2:0] res_to_flags_n(input res_t res);
        logic [2:0] flags;
        case (res)
            RES_EQ:  flags = 3'b011;
            RES_GT:  flags = 3'b101;
            RES_LT:  flags = 3'b110;
            default: flags = FLAGS_NONE;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/seq_mag_cmp_cmp_word.sv
// ----------------------------------------------------------------------------
// cmp_word
// Combinational WIDTH-bit word compare.
// Parameters:
//   WIDTH      - word width (>= 2)
//   SIGNED_CMP - 1: a word flagged by i_signed_word is compared as two's
//                complement; 0: every word is compared unsigned
// Ports:
//   i_a, i_b       - words to compare
//   i_signed_word  - this word carries the operand sign (only honoured when
//                    SIGNED_CMP=1)
//   o_eq           - i_a == i_b
//   o_gt           - i_a > i_b (signed or unsigned as above)
// ----------------------------------------------------------------------------
module cmp_word #(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed_word,
    output logic             o_eq,
    output logic             o_gt
);

    logic             w_flip;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    // Inverting both sign bits turns a two's complement compare into an
    // unsigned one (offset-binary), so a single unsigned comparator serves
    // both cases. With SIGNED_CMP=0 the flip is constant zero.
    assign w_flip = SIGNED_CMP & i_signed_word;
    assign w_a    = {i_a[WIDTH-1] ^ w_flip, i_a[WIDTH-2:0]};
    assign w_b    = {i_b[WIDTH-1] ^ w_flip, i_b[WIDTH-2:0]};

    assign o_eq = (i_a == i_b);
    assign o_gt = (w_a > w_b);

endmodule

// File: rtl/seq_mag_cmp.sv
// ----------------------------------------------------------------------------
// seq_mag_cmp
// Sequential multi-word magnitude comparator. Operands P and Q arrive one
// word per accepted strobe, most-significant word first; the first non-equal
// word decides the result, which is held until the next start or reset.
// Configuration macro: SEQ_MAG_CMP_SIGNED_EN
//   defined   - operands are two's complement (start word compared signed)
//   undefined - all words compared unsigned
// Parameters: WIDTH (bits per word, >= 2), WORDS (words per operand, >= 1)
// Ports:
//   clk      - clock, rising edge
//   clr_n    - synchronous active-low reset
//   g_n      - active-low enable; high freezes all state (except reset)
//   start    - marks the strobed word as the MSW of a new compare
//   wr       - word strobe
//   p, q     - operand words
//   p_eq_q_n, p_gt_q_n, p_lt_q_n - registered active-low results (DONE only)
//   busy     - compare in progress (RUN)
//   done     - result valid (DONE)
//   cnt      - words accepted in the current compare
// ----------------------------------------------------------------------------
module seq_mag_cmp
    import seq_mag_cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                         clk,
    input  logic                         clr_n,
    input  logic                         g_n,
    input  logic                         start,
    input  logic                         wr,
    input  logic [WIDTH-1:0]             p,
    input  logic [WIDTH-1:0]             q,
    output logic                         p_eq_q_n,
    output logic                         p_gt_q_n,
    output logic                         p_lt_q_n,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WORDS+1)-1:0]   cnt
);

    localparam int            CW       = $clog2(WORDS + 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

`ifdef SEQ_MAG_CMP_SIGNED_EN
    localparam bit SIGNED_MSW = 1'b1;
`else
    localparam bit SIGNED_MSW = 1'b0;
`endif

    state_t        r_state;
    res_t          r_res;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_flags_n;
    logic          r_busy;
    logic          r_done;

    logic          w_eq;
    logic          w_gt;
    res_t          w_word_res;
    res_t          w_acc_res;

    // The start word is the MSW, the only one that carries the sign.
    cmp_word #(
        .WIDTH      (WIDTH),
        .SIGNED_CMP (SIGNED_MSW)
    ) u_cmp_word (
        .i_a           (p),
        .i_b           (q),
        .i_signed_word (start),
        .o_eq          (w_eq),
        .o_gt          (w_gt)
    );

    // Encode this word's compare and fold it into the sticky result: once a
    // word differs, later (less significant) words cannot change the outcome.
    always_comb begin
        w_word_res = RES_LT;
        w_acc_res  = r_res;
        if (w_eq) begin
            w_word_res = RES_EQ;
        end else if (w_gt) begin
            w_word_res = RES_GT;
        end else begin
            w_word_res = RES_LT;
        end
        if (r_res == RES_EQ) begin
            w_acc_res = w_word_res;
        end else begin
            w_acc_res = r_res;
        end
    end

    // FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state   <= ST_IDLE;
            r_res     <= RES_EQ;
            r_cnt     <= '0;
            r_flags_n <= FLAGS_NONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (!g_n && wr) begin
            if (start) begin
                // New compare (also aborts one in progress).
                r_res <= w_word_res;
                r_cnt <= ONE_CNT;
                if (WORDS == 1) begin
                    r_state   <= ST_DONE;
                    r_flags_n <= res_to_flags_n(w_word_res);
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                end else begin
                    r_state   <= ST_RUN;
                    r_flags_n <= FLAGS_NONE;
                    r_busy    <= 1'b1;
                    r_done    <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_RUN: begin
                        r_res <= w_acc_res;
                        r_cnt <= r_cnt + ONE_CNT;
                        if (r_cnt == LAST_CNT) begin
                            r_state   <= ST_DONE;
                            r_flags_n <= res_to_flags_n(w_acc_res);
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_IDLE, ST_DONE: begin
                        // Words without start are ignored outside RUN.
                        r_state <= r_state;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_res     <= RES_EQ;
                        r_cnt     <= '0;
                        r_flags_n <= FLAGS_NONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b0;
                    end
                endcase
            end
        end else begin
            r_state <= r_state;
        end
    end

    assign p_eq_q_n = r_flags_n[2];
    assign p_gt_q_n = r_flags_n[1];
    assign p_lt_q_n = r_flags_n[0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign cnt      = r_cnt;

endmodule

// File: tb/tb_seq_mag_cmp.sv
// ----------------------------------------------------------------------------
// tb_seq_mag_cmp
// Scoreboard bench: the stimulus pushes the expected result of each compare
// when it issues the words; per-DUT monitors pop and compare on every rising
// edge of done. Two instances: WORDS=2 and WORDS=1 (WIDTH=8 both).
// ----------------------------------------------------------------------------
module tb_seq_mag_cmp;

    typedef struct {
        logic [2:0] flags;
        int         cnt;
    } exp_t;

    logic       clk;
    logic       clr_n;
    logic       g_n;
    logic       start, wr;
    logic [7:0] p, q;
    logic       eq_n, gt_n, lt_n, busy, done;
    logic [1:0] cnt;

    logic       start1, wr1;
    logic [7:0] p1, q1;
    logic       eq1_n, gt1_n, lt1_n, busy1, done1;
    logic [0:0] cnt1;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t exp1_q[$];
    logic done_q  = 1'b0;
    logic done1_q = 1'b0;

    seq_mag_cmp #(.WIDTH(8), .WORDS(2)) u_dut (
        .clk(clk), .clr_n(clr_n), .g_n(g_n), .start(start), .wr(wr),
        .p(p), .q(q), .p_eq_q_n(eq_n), .p_gt_q_n(gt_n), .p_lt_q_n(lt_n),
        .busy(busy), .done(done), .cnt(cnt)
    );

    seq_mag_cmp #(.WIDTH(8), .WORDS(1)) u_dut1 (
        .clk(clk), .clr_n(clr_n), .g_n(g_n), .start(start1), .wr(wr1),
        .p(p1), .q(q1), .p_eq_q_n(eq1_n), .p_gt_q_n(gt1_n), .p_lt_q_n(lt1_n),
        .busy(busy1), .done(done1), .cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one word into the WORDS=2 instance; returns 1 time unit after the edge.
    task automatic send(input logic s, input logic [7:0] a, input logic [7:0] b);
        start = s; wr = 1'b1; p = a; q = b;
        @(posedge clk); #1;
        wr = 1'b0; start = 1'b0;
    endtask

    task automatic send1(input logic s, input logic [7:0] a, input logic [7:0] b);
        start1 = s; wr1 = 1'b1; p1 = a; q1 = b;
        @(posedge clk); #1;
        wr1 = 1'b0; start1 = 1'b0;
    endtask

    task automatic push(input logic [2:0] f, input int c);
        exp_t e;
        e.flags = f;
        e.cnt   = c;
        exp_q.push_back(e);
    endtask

    // Monitor for the WORDS=2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1 && done_q !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no result");
            end else begin
                e = exp_q.pop_front();
                chk("result", {29'd0, eq_n, gt_n, lt_n}, {29'd0, e.flags});
                chk("done_cnt", {30'd0, cnt}, e.cnt);
                chk("done_busy", {31'd0, busy}, 32'd0);
            end
        end
        done_q = done;
    end

    // Monitor for the WORDS=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (done1 === 1'b1 && done1_q !== 1'b1) begin
            if (exp1_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_done1: got done=1 expected no result");
            end else begin
                e = exp1_q.pop_front();
                chk("result1", {29'd0, eq1_n, gt1_n, lt1_n}, {29'd0, e.flags});
                chk("done_cnt1", {31'd0, cnt1}, e.cnt);
            end
        end
        done1_q = done1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1;
        clr_n = 1'b0; g_n = 1'b0; start = 1'b0; wr = 1'b0; p = 8'h00; q = 8'h00;
        start1 = 1'b0; wr1 = 1'b0; p1 = 8'h00; q1 = 8'h00;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cnt", {30'd0, cnt}, 32'd0);
        chk("rst_flags", {29'd0, eq_n, gt_n, lt_n}, 32'd7);
        chk("rst_done1", {31'd0, done1}, 32'd0);
        clr_n = 1'b1;

        // Word without start in IDLE is ignored.
        send(1'b0, 8'h12, 8'h34);
        chk("idle_ign_cnt", {30'd0, cnt}, 32'd0);
        chk("idle_ign_busy", {31'd0, busy}, 32'd0);

        // Reset mid-RUN discards the partial compare.
        send(1'b1, 8'h11, 8'h22);
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_cnt", {30'd0, cnt}, 32'd1);
        chk("run_flags", {29'd0, eq_n, gt_n, lt_n}, 32'd7);
        clr_n = 1'b0;
        @(posedge clk); #1;
        clr_n = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_cnt", {30'd0, cnt}, 32'd0);
        chk("midrst_flags", {29'd0, eq_n, gt_n, lt_n}, 32'd7);
        send(1'b0, 8'h33, 8'h33);
        chk("postrst_ign_cnt", {30'd0, cnt}, 32'd0);
        chk("postrst_ign_busy", {31'd0, busy}, 32'd0);

        // Equal operands; done one clock after the last word.
        send(1'b1, 8'hA5, 8'hA5);
        push(3'b011, 2);
        send(1'b0, 8'h3C, 8'h3C);
        chk("eq_latency_done", {31'd0, done}, 32'd1);

        // Sticky MSW result: GT decided by first word, then LT by second word.
        push(3'b101, 2);
        send(1'b1, 8'h01, 8'h00);
        send(1'b0, 8'h00, 8'hFF);
        push(3'b110, 2);
        send(1'b1, 8'h00, 8'h00);
        send(1'b0, 8'h10, 8'h11);

        // Freeze with g_n high, then abort by a new start.
        send(1'b1, 8'h55, 8'h66);
        g_n = 1'b1; wr = 1'b1; start = 1'b0; p = 8'h01; q = 8'h02;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("freeze_cnt", {30'd0, cnt}, 32'd1);
            chk("freeze_busy", {31'd0, busy}, 32'd1);
        end
        wr = 1'b0; g_n = 1'b0;
        push(3'b011, 2);
        send(1'b1, 8'h22, 8'h22);
        chk("abort_cnt", {30'd0, cnt}, 32'd1);
        send(1'b0, 8'h00, 8'h00);

        // Sign of the MSW.
`ifdef SEQ_MAG_CMP_SIGNED_EN
        push(3'b110, 2);
`else
        push(3'b101, 2);
`endif
        send(1'b1, 8'h80, 8'h7F);
        send(1'b0, 8'h00, 8'h00);
        @(negedge clk);

        // Word without start in DONE leaves the result held.
        send(1'b0, 8'h00, 8'hFF);
`ifdef SEQ_MAG_CMP_SIGNED_EN
        chk("done_hold_flags", {29'd0, eq_n, gt_n, lt_n}, 32'd6);
`else
        chk("done_hold_flags", {29'd0, eq_n, gt_n, lt_n}, 32'd5);
`endif
        chk("done_hold_done", {31'd0, done}, 32'd1);
        chk("done_hold_cnt", {30'd0, cnt}, 32'd2);

        // Decision in the least significant word.
        push(3'b101, 2);
        send(1'b1, 8'h07, 8'h07);
        send(1'b0, 8'h09, 8'h08);

        // WORDS=1 instance.
        e1.flags = 3'b101;
        e1.cnt   = 1;
        exp1_q.push_back(e1);
        send1(1'b1, 8'hFF, 8'hFE);
        chk("w1_latency_done", {31'd0, done1}, 32'd1);
        chk("w1_busy", {31'd0, busy1}, 32'd0);
        @(negedge clk);
        send1(1'b0, 8'h00, 8'hFF);
        chk("w1_hold_flags", {29'd0, eq1_n, gt1_n, lt1_n}, 32'd5);
        chk("w1_hold_done", {31'd0, done1}, 32'd1);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("scoreboard1_empty", exp1_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
